bandai_bus_sequencer: RTL and testbench

Host-side bus master that unlocks the Bandai 2003 mapper and then sequences all accesses to its bank registers. After reset it issues the two-address unlock key and captures the mapper's 18-bit SO response. It then optionally loads default bank values. From then on it serialises host read and write commands into correctly strobed CEn/SSn/WEn/OEn bus cycles.

---
 rtl/bandai_bus_sequencer.sv | 143 ++++++++++++++
 tb/tb_bandai_bus_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bandai_bus_sequencer.sv
// bandai_bus_sequencer: unlocks the Bandai 2003 mapper, checks its SO signature,
// optionally loads default banks, then serialises host register reads/writes.
module bandai_bus_sequencer #(
  parameter int unsigned WR_CYC     = 2,
  parameter int unsigned RD_CYC     = 2,
  parameter logic [17:0] UNLOCK_SIG = 18'h05140,
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [31:0] INIT_BANKS = 32'hFFFFFFFF
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       unlocked,
  output logic       unlock_fail,
  input  logic       SO,
  output logic [7:0] bus_addr,
  output logic       CEn,
  output logic       SSn,
  output logic       WEn,
  output logic       OEn,
  output logic [7:0] bus_dq_o,
  output logic       bus_dq_oe,
  input  logic [7:0] bus_dq_i
);
  localparam logic [3:0] KEY1   = 4'd0;
  localparam logic [3:0] KEY2   = 4'd1;
  localparam logic [3:0] SIG    = 4'd2;
  localparam logic [3:0] CHK    = 4'd3;
  localparam logic [3:0] INIT   = 4'd4;
  localparam logic [3:0] IDLE   = 4'd5;
  localparam logic [3:0] WR_SET = 4'd6;
  localparam logic [3:0] WR_STB = 4'd7;
  localparam logic [3:0] WR_REL = 4'd8;
  localparam logic [3:0] RD_ACC = 4'd9;
  localparam logic [3:0] RD_CAP = 4'd10;
  localparam logic [3:0] FAIL   = 4'd11;

  logic [3:0]  state;
  logic [4:0]  cnt;
  logic [17:0] sig;
  logic [1:0]  idx;
  logic        init_mode;
  logic [1:0]  reg_l;
  logic [7:0]  data_l;
  logic        wr, rd;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= KEY1;
      cnt         <= '0;
      sig         <= '0;
      idx         <= '0;
      init_mode   <= 1'b0;
      reg_l       <= '0;
      data_l      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      unlocked    <= 1'b0;
      unlock_fail <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        KEY1: state <= KEY2;
        KEY2: state <= SIG;
        SIG: begin
          sig <= {SO, sig[17:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd17) begin
            cnt   <= '0;
            state <= CHK;
          end
        end
        CHK: begin
          if (sig == UNLOCK_SIG) begin
            unlocked  <= 1'b1;
            init_mode <= INIT_EN;
            state     <= INIT_EN ? INIT : IDLE;
          end else begin
            unlock_fail <= 1'b1;
            state       <= FAIL;
          end
        end
        INIT: begin
          reg_l  <= idx;
          data_l <= INIT_BANKS[{idx, 3'b000} +: 8];
          state  <= WR_SET;
        end
        IDLE: if (cmd_valid) begin
          reg_l  <= cmd_reg;
          data_l <= cmd_data;
          state  <= cmd_we ? WR_SET : RD_ACC;
        end
        WR_SET: state <= WR_STB;
        WR_STB: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(WR_CYC - 1)) begin
            cnt   <= '0;
            state <= WR_REL;
          end
        end
        WR_REL: begin
          // init writes walk C0h..C3h, host writes go straight back to IDLE
          if (init_mode) begin
            idx       <= idx + 2'd1;
            init_mode <= idx != 2'd3;
            state     <= idx == 2'd3 ? IDLE : INIT;
          end else
            state <= IDLE;
        end
        RD_ACC: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(RD_CYC - 1)) begin
            cnt   <= '0;
            state <= RD_CAP;
          end
        end
        RD_CAP: begin
          rsp_data  <= bus_dq_i;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= FAIL;
      endcase
    end
  end

  assign wr        = state == WR_SET || state == WR_STB || state == WR_REL;
  assign rd        = state == RD_ACC || state == RD_CAP;
  assign cmd_ready = state == IDLE;
  assign CEn       = 1'b1;
  assign SSn       = !(wr || rd);
  assign WEn       = state != WR_STB;
  assign OEn       = !rd;
  assign bus_dq_oe = wr;
  assign bus_dq_o  = data_l;
  assign bus_addr  = state == KEY1 ? 8'h5A : state == KEY2 ? 8'hA5 : (wr || rd) ? {6'b110000, reg_l} : 8'h00;
endmodule

// File: tb/tb_bandai_bus_sequencer.sv
// tb_bandai_bus_sequencer: directed checks of unlock, init, host writes/reads,
// mid-write reset, failed unlock and a WR_CYC=4/RD_CYC=1 variant.
module tb_bandai_bus_sequencer;
  localparam logic [17:0] PAT = 18'h05140;

  logic CLK = 1'b0, RSTn = 1'b0, rst_b = 1'b0;
  always #5 CLK = ~CLK;

  logic       cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [1:0] cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  bit         force_one = 1'b0;
  int         checks = 0, errors = 0, cyc = 0, ea = 0, eb = 0, viol = 0;
  logic [7:0] mreg [4] = '{default: 8'h00};
  logic [7:0] mreg_b [4] = '{default: 8'h00};

  logic       cmd_ready, rsp_valid, unlocked, unlock_fail, SO, CEn, SSn, WEn, OEn, bus_dq_oe;
  logic [7:0] rsp_data, bus_addr, bus_dq_o, bus_dq_i;
  logic       cmd_ready_b, rsp_valid_b, unlocked_b, unlock_fail_b, SO_b, CEn_b, SSn_b, WEn_b, OEn_b, bus_dq_oe_b;
  logic [7:0] rsp_data_b, bus_addr_b, bus_dq_o_b, bus_dq_i_b;

  bandai_bus_sequencer ua (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .unlocked(unlocked), .unlock_fail(unlock_fail), .SO(SO), .bus_addr(bus_addr), .CEn(CEn),
    .SSn(SSn), .WEn(WEn), .OEn(OEn), .bus_dq_o(bus_dq_o), .bus_dq_oe(bus_dq_oe), .bus_dq_i(bus_dq_i)
  );

  bandai_bus_sequencer #(.WR_CYC(4), .RD_CYC(1), .INIT_EN(1'b0)) ub (
    .CLK(CLK), .RSTn(rst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_we(cmd_we),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .unlocked(unlocked_b), .unlock_fail(unlock_fail_b), .SO(SO_b), .bus_addr(bus_addr_b), .CEn(CEn_b),
    .SSn(SSn_b), .WEn(WEn_b), .OEn(OEn_b), .bus_dq_o(bus_dq_o_b), .bus_dq_oe(bus_dq_oe_b), .bus_dq_i(bus_dq_i_b)
  );

  // mapper models: SO bit k is presented for sampling at edge 3+k after reset release
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK or negedge RSTn) if (!RSTn) ea <= 0; else ea <= ea + 1;
  always @(posedge CLK or negedge rst_b) if (!rst_b) eb <= 0; else eb <= eb + 1;
  assign SO   = force_one | ((ea >= 2 && ea <= 19) ? PAT[5'(ea - 2)] : 1'b0);
  assign SO_b = (eb >= 2 && eb <= 19) ? PAT[5'(eb - 2)] : 1'b0;
  assign bus_dq_i   = !OEn ? mreg[bus_addr[1:0]] : 8'h00;
  assign bus_dq_i_b = !OEn_b ? mreg_b[bus_addr_b[1:0]] : 8'h00;
  always @(posedge WEn) if (RSTn && !SSn && CEn && bus_addr[7:2] == 6'b110000) mreg[bus_addr[1:0]] <= bus_dq_o;
  always @(posedge WEn_b) if (rst_b && !SSn_b && CEn_b && bus_addr_b[7:2] == 6'b110000) mreg_b[bus_addr_b[1:0]] <= bus_dq_o_b;
  always @(negedge CLK) if ((!OEn && (!WEn || bus_dq_oe)) || (!OEn_b && (!WEn_b || bus_dq_oe_b)) || !CEn || !CEn_b) viol <= viol + 1;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // call at a negedge; returns at the negedge right after the handshake edge
  task automatic issue(input bit sel, input bit we, input logic [1:0] r, input logic [7:0] d);
    int k = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_reg = r; cmd_data = d;
    while (!(sel ? cmd_ready_b : cmd_ready) && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk("handshake_wait", 32'(k < 60), 32'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    int hs [4];
    logic [4:0] rv;
    logic [5:0] wv;
    logic [3:0] rv4;
    int idle_bad;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_data, unlocked, unlock_fail, CEn, SSn, WEn, OEn, bus_dq_oe},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    RSTn = 1'b1;
    chk("key1_addr", bus_addr, 8'h5A);
    @(negedge CLK);
    chk("key2_addr", {bus_addr, SSn, WEn, OEn}, {8'hA5, 3'b111});
    @(negedge CLK);
    chk("sig_addr", {bus_addr, SSn}, {8'h00, 1'b1});
    repeat (18) @(negedge CLK);
    chk("unlocked_before_e21", unlocked, 1'b0);
    @(negedge CLK);
    chk("unlocked_after_e21", {unlocked, unlock_fail, cmd_ready}, 3'b100);
    k = 0;
    while (!cmd_ready && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk("init_length", k, 20);
    chk("init_banks", {mreg[3], mreg[2], mreg[1], mreg[0]}, 32'hFFFFFFFF);

    issue(1'b0, 1'b1, 2'd2, 8'h3C);
    chk("wr_set", {bus_addr, SSn, WEn, bus_dq_oe, bus_dq_o, OEn}, {8'hC2, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1});
    @(negedge CLK);
    chk("wr_stb1", {WEn, SSn}, 2'b00);
    @(negedge CLK);
    chk("wr_stb2", WEn, 1'b0);
    @(negedge CLK);
    chk("wr_rel", {WEn, SSn, bus_dq_oe, bus_addr, cmd_ready}, {1'b1, 1'b0, 1'b1, 8'hC2, 1'b0});
    @(negedge CLK);
    chk("wr_done", {cmd_ready, SSn, bus_addr}, {1'b1, 1'b1, 8'h00});
    chk("mapper_c2", mreg[2], 8'h3C);

    issue(1'b0, 1'b0, 2'd2, 8'h00);
    chk("rd_acc", {bus_addr, SSn, OEn, WEn, bus_dq_oe}, {8'hC2, 1'b0, 1'b0, 1'b1, 1'b0});
    rv[0] = rsp_valid;
    for (int i = 1; i < 5; i++) begin
      @(negedge CLK);
      rv[i] = rsp_valid;
    end
    chk("rd_valid_pulse", rv, 5'b01000);
    chk("rd_data", rsp_data, 8'h3C);

    cmd_valid = 1'b1; cmd_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_reg = 2'(i);
      cmd_data = 8'(8'h11 * (i + 1));
      k = 0;
      while (!cmd_ready && k < 20) begin
        @(negedge CLK);
        k++;
      end
      hs[i] = cyc;
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("b2b_gap01", hs[1] - hs[0], 5);
    chk("b2b_gap12", hs[2] - hs[1], 5);
    chk("b2b_gap23", hs[3] - hs[2], 5);
    chk("b2b_regs", {mreg[3], mreg[2], mreg[1], mreg[0]}, 32'h44332211);

    issue(1'b0, 1'b1, 2'd1, 8'h55);
    @(negedge CLK);
    chk("mid_wr_stb", WEn, 1'b0);
    #2 RSTn = 1'b0;
    #1 chk("async_release", {WEn, bus_dq_oe, SSn, cmd_ready}, 4'b1010);
    force_one = 1'b1;
    @(negedge CLK);
    RSTn = 1'b1;
    chk("rekey1", bus_addr, 8'h5A);
    @(negedge CLK);
    chk("rekey2", bus_addr, 8'hA5);
    repeat (20) @(negedge CLK);
    chk("fail_flags", {unlock_fail, unlocked, cmd_ready}, 3'b100);
    cmd_valid = 1'b1; cmd_we = 1'b1;
    idle_bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (cmd_ready || {CEn, SSn, WEn, OEn, bus_dq_oe, bus_addr} !== {5'b11110, 8'h00}) idle_bad++;
    end
    cmd_valid = 1'b0;
    chk("fail_bus_idle", idle_bad, 0);

    rst_b = 1'b1;
    repeat (21) @(negedge CLK);
    chk("b_unlocked", {unlocked_b, unlock_fail_b, cmd_ready_b}, 3'b101);
    issue(1'b1, 1'b1, 2'd3, 8'hA7);
    wv[0] = WEn_b;
    for (int i = 1; i < 6; i++) begin
      @(negedge CLK);
      wv[i] = WEn_b;
    end
    chk("b_wen_low4", wv, 6'b100001);
    @(negedge CLK);
    chk("b_ready_back", cmd_ready_b, 1'b1);
    chk("b_mapper_c3", mreg_b[3], 8'hA7);
    issue(1'b1, 1'b0, 2'd3, 8'h00);
    rv4[0] = rsp_valid_b;
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      rv4[i] = rsp_valid_b;
    end
    chk("b_rd_valid", rv4, 4'b0100);
    chk("b_rd_data", rsp_data_b, 8'hA7);
    chk("no_strobe_overlap", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
